pc_sequencer: RTL and testbench
===============================

// Module: pc_sequencer
// PURPOSE
//  Parametrised program counter for the 14500 system, replacing the fixed 16-bit load/hold PC.
//  Adds increment, skip-if-zero (SKZ), jump, and call/return through a hardware return stack of
//  configurable depth, with sticky stack-error flags. Drives the program ROM address bus and
//  takes control strobes from the instruction decoder.
// PARAMETERS
//  AW          16   address width in bits (PC, addr_in, addr_out)
//  DEPTH       4    return-stack entries (>=1)
//  RESET_ADDR  0    PC value loaded on reset (AW bits)
// PORTS
//  pc_clk      in   1      clock, all state updates on rising edge
//  reset       in   1      asynchronous, active-low reset
//  en          in   1      advance strobe; when 0 all state holds
//  jmp         in   1      load PC from addr_in
//  call        in   1      push PC+1, load PC from addr_in
//  rtn         in   1      pop stack into PC
//  skz         in   1      skip next instruction if rr==0
//  rr          in   1      result register bit from the ICU
//  addr_in     in   AW     jump/call target
//  addr_out    out  AW     current PC (registered)
//  depth_out   out  clog2(DEPTH+1)  entries currently on stack
//  ovf         out  1      sticky: call attempted with stack full
//  unf         out  1      sticky: rtn attempted with stack empty
// BEHAVIOUR
//  - reset low (any time, incl. mid-operation): addr_out=RESET_ADDR, depth_out=0, ovf=0, unf=0;
//    stack contents are don't-care. Held while reset is low; first update on first pc_clk
//    rising edge after reset goes high.
//  - addr_out is the PC register itself; a change takes effect 1 cycle after the en edge.
//  - en=0: PC, stack, depth, and flags hold; all strobes are ignored.
//  - en=1, one action per cycle, priority rtn > call > jmp > skz > increment:
//    rtn, depth>0: PC<=stack[top], depth-=1
//    rtn, depth==0: PC<=PC+1, unf<=1, depth stays 0
//    call, depth<DEPTH: stack[depth]<=PC+1, depth+=1, PC<=addr_in
//    call, depth==DEPTH: PC<=addr_in, push dropped, depth unchanged, ovf<=1
//    jmp: PC<=addr_in, stack untouched
//    skz & rr==0: PC<=PC+2; skz & rr==1: PC<=PC+1
//    none asserted: PC<=PC+1
//  - Lower-priority strobes asserted together with a higher one are ignored entirely.
//  - Arithmetic is modulo 2^AW: PC+1 at all-ones -> 0; PC+2 at all-ones -> 1.
//    Pushed return address wraps the same way.
//  - ovf/unf are sticky until reset; they do not block further operation.
//  - Stack is LIFO; top = entry depth-1. No combinational path from inputs to outputs.
// TESTING (AW=16, DEPTH=4, RESET_ADDR=0)
//  1. Release reset, en=1 for 3 cycles -> addr_out 0,1,2,3.
//     Pull reset low mid-count -> addr_out=0 immediately (async), flags 0.
//  2. PC=0x0010, skz=1 & rr=0 -> 0x0012; skz=1 & rr=1 -> 0x0013; PC=0xFFFF plain en -> 0x0000;
//     PC=0xFFFF skz & rr=0 -> 0x0001.
//  3. PC=0x0020, call to 0x0100 -> PC=0x0100, depth=1; rtn -> PC=0x0021, depth=0.
//  4. Five nested calls from PC=0x0000,0x0100.. -> depth saturates at 4, ovf=1 after fifth.
//     Four rtns unwind in LIFO order; fifth rtn -> PC+1, unf=1.
//  5. Same cycle: rtn+call+jmp with depth=1 -> pop wins, addr_in ignored.
//     jmp+skz(rr=0) -> PC=addr_in.
//  6. en=0 with jmp/call/rtn pulsed -> addr_out, depth_out, ovf, unf unchanged.

Source files
------------

// File: rtl/pc_sequencer.sv
// Program counter with increment, skip-if-zero, jump and call/return through
// a small hardware return stack. Sticky flags record stack overflow/underflow.
//
// action     | meaning
// -----------+------------------------------------------------------------
// ACT_HOLD   | en low: PC, stack, depth and flags keep their values
// ACT_POP    | rtn with entries present: PC <= top of stack, depth - 1
// ACT_UNF    | rtn on empty stack: PC + 1, unf set
// ACT_PUSH   | call with room: push PC + 1, PC <= addr_in, depth + 1
// ACT_OVF    | call on full stack: PC <= addr_in, push dropped, ovf set
// ACT_JMP    | jmp: PC <= addr_in
// ACT_SKIP   | skz with rr == 0: PC + 2
// ACT_INC    | no strobe, or skz with rr == 1: PC + 1
module pc_sequencer #(
   parameter int             AW         = 16,
   parameter int             DEPTH      = 4,
   parameter logic [AW-1:0]  RESET_ADDR = '0,
   localparam int            DW         = $clog2(DEPTH + 1),
   localparam int            IW         = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic          pc_clk,
   input  logic          reset,
   input  logic          en,
   input  logic          jmp,
   input  logic          call,
   input  logic          rtn,
   input  logic          skz,
   input  logic          rr,
   input  logic [AW-1:0] addr_in,
   output logic [AW-1:0] addr_out,
   output logic [DW-1:0] depth_out,
   output logic          ovf,
   output logic          unf
);

   typedef enum logic [2:0] {
      ACT_HOLD,
      ACT_POP,
      ACT_UNF,
      ACT_PUSH,
      ACT_OVF,
      ACT_JMP,
      ACT_SKIP,
      ACT_INC
   } act_t;

   act_t          act;
   logic [AW-1:0] pc;
   logic [DW-1:0] depth;
   logic          ovf_q;
   logic          unf_q;
   logic [AW-1:0] stack [DEPTH];

   logic [AW-1:0] pc_plus1;
   logic [AW-1:0] pc_plus2;
   logic [AW-1:0] pc_nxt;
   logic [DW-1:0] depth_nxt;
   logic          ovf_nxt;
   logic          unf_nxt;
   logic          push_we;
   logic [IW-1:0] push_idx;
   logic [IW-1:0] pop_idx;
   logic          stack_full;
   logic          stack_empty;

   // Both sums wrap modulo 2^AW, including the pushed return address.
   assign pc_plus1    = pc + AW'(1);
   assign pc_plus2    = pc + AW'(2);
   assign stack_full  = (depth == DW'(DEPTH));
   assign stack_empty = (depth == '0);
   assign push_idx    = IW'(depth);
   assign pop_idx     = IW'(depth - DW'(1));

   // Pick the single action for this cycle: rtn > call > jmp > skz > increment.
   always_comb begin
      act = ACT_HOLD;
      if (en) begin
         if (rtn)
            act = stack_empty ? ACT_UNF : ACT_POP;
         else if (call)
            act = stack_full ? ACT_OVF : ACT_PUSH;
         else if (jmp)
            act = ACT_JMP;
         else if (skz && !rr)
            act = ACT_SKIP;
         else
            act = ACT_INC;
      end
   end

   // Next PC, depth, flags and stack write enable for the chosen action.
   always_comb begin
      pc_nxt    = pc;
      depth_nxt = depth;
      ovf_nxt   = ovf_q;
      unf_nxt   = unf_q;
      push_we   = 1'b0;
      unique case (act)
         ACT_POP: begin
            pc_nxt    = stack[pop_idx];
            depth_nxt = depth - DW'(1);
         end
         ACT_UNF: begin
            pc_nxt  = pc_plus1;
            unf_nxt = 1'b1;
         end
         ACT_PUSH: begin
            pc_nxt    = addr_in;
            depth_nxt = depth + DW'(1);
            push_we   = 1'b1;
         end
         ACT_OVF: begin
            pc_nxt  = addr_in;
            ovf_nxt = 1'b1;
         end
         ACT_JMP:  pc_nxt = addr_in;
         ACT_SKIP: pc_nxt = pc_plus2;
         ACT_INC:  pc_nxt = pc_plus1;
         default:  pc_nxt = pc;
      endcase
   end

   // Control state: PC, stack depth and sticky error flags.
   always_ff @(posedge pc_clk or negedge reset) begin
      if (!reset) begin
         pc    <= RESET_ADDR;
         depth <= '0;
         ovf_q <= 1'b0;
         unf_q <= 1'b0;
      end else begin
         pc    <= pc_nxt;
         depth <= depth_nxt;
         ovf_q <= ovf_nxt;
         unf_q <= unf_nxt;
      end
   end

   // Stack contents need no reset; depth alone decides which entries are valid.
   always_ff @(posedge pc_clk) begin
      if (push_we)
         stack[push_idx] <= pc_plus1;
   end

   assign addr_out  = pc;
   assign depth_out = depth;
   assign ovf       = ovf_q;
   assign unf       = unf_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios followed by random
// strobes, compared every cycle against a queue-based behavioural model.
module tb_pc_sequencer;

   localparam int AW    = 16;
   localparam int DEPTH = 4;
   localparam int DW    = $clog2(DEPTH + 1);

   logic          pc_clk;
   logic          reset;
   logic          en;
   logic          jmp;
   logic          call;
   logic          rtn;
   logic          skz;
   logic          rr;
   logic [AW-1:0] addr_in;
   logic [AW-1:0] addr_out;
   logic [DW-1:0] depth_out;
   logic          ovf;
   logic          unf;

   int n_tests = 0;
   int n_fail  = 0;

   // reference model
   logic [AW-1:0] m_pc;
   logic [AW-1:0] m_stack [$];
   logic          m_ovf;
   logic          m_unf;

   pc_sequencer #(.AW(AW), .DEPTH(DEPTH), .RESET_ADDR('0)) dut (
      .pc_clk    (pc_clk),
      .reset     (reset),
      .en        (en),
      .jmp       (jmp),
      .call      (call),
      .rtn       (rtn),
      .skz       (skz),
      .rr        (rr),
      .addr_in   (addr_in),
      .addr_out  (addr_out),
      .depth_out (depth_out),
      .ovf       (ovf),
      .unf       (unf)
   );

   initial pc_clk = 1'b0;
   always #5 pc_clk = ~pc_clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_pc  = '0;
      m_stack.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
   endtask

   // One rising edge of the program counter as described by its rules.
   task automatic model_step();
      if (!en) return;
      if (rtn) begin
         if (m_stack.size() > 0) m_pc = m_stack.pop_back();
         else begin
            m_pc  = m_pc + 16'd1;
            m_unf = 1'b1;
         end
      end else if (call) begin
         if (m_stack.size() < DEPTH) m_stack.push_back(m_pc + 16'd1);
         else m_ovf = 1'b1;
         m_pc = addr_in;
      end else if (jmp) begin
         m_pc = addr_in;
      end else if (skz && !rr) begin
         m_pc = m_pc + 16'd2;
      end else begin
         m_pc = m_pc + 16'd1;
      end
   endtask

   task automatic check_all(input string tag);
      check_val({tag, ".addr"},  32'(addr_out),  32'(m_pc));
      check_val({tag, ".depth"}, 32'(depth_out), 32'(m_stack.size()));
      check_val({tag, ".ovf"},   32'(ovf),       32'(m_ovf));
      check_val({tag, ".unf"},   32'(unf),       32'(m_unf));
   endtask

   // Drive one cycle of inputs, clock it, update the model and compare.
   task automatic step(input string tag, input logic e, input logic j, input logic c,
                       input logic r, input logic s, input logic rv, input logic [AW-1:0] a);
      en = e; jmp = j; call = c; rtn = r; skz = s; rr = rv; addr_in = a;
      @(posedge pc_clk);
      model_step();
      #1;
      check_all(tag);
   endtask

   initial begin
      reset = 1'b0;
      en = 0; jmp = 0; call = 0; rtn = 0; skz = 0; rr = 0; addr_in = '0;
      model_reset();
      repeat (3) @(posedge pc_clk);
      #1;
      check_all("reset_hold");
      @(negedge pc_clk);
      reset = 1'b1;
      #4;

      // count from reset
      step("count1", 1, 0, 0, 0, 0, 0, 16'h0000);
      step("count2", 1, 0, 0, 0, 0, 0, 16'h0000);
      step("count3", 1, 0, 0, 0, 0, 0, 16'h0000);
      check_val("count3_const", 32'(addr_out), 32'h3);

      // async reset in the middle of a cycle
      #2 reset = 1'b0;
      model_reset();
      #1;
      check_all("async_rst");
      @(negedge pc_clk);
      reset = 1'b1;
      #4;

      // skip / wrap
      step("jmp10",    1, 1, 0, 0, 0, 0, 16'h0010);
      step("skz_rr0",  1, 0, 0, 0, 1, 0, 16'h0000);
      check_val("skz_rr0_const", 32'(addr_out), 32'h12);
      step("skz_rr1",  1, 0, 0, 0, 1, 1, 16'h0000);
      check_val("skz_rr1_const", 32'(addr_out), 32'h13);
      step("jmpffff",  1, 1, 0, 0, 0, 0, 16'hFFFF);
      step("wrap1",    1, 0, 0, 0, 0, 0, 16'h0000);
      check_val("wrap1_const", 32'(addr_out), 32'h0);
      step("jmpffff2", 1, 1, 0, 0, 0, 0, 16'hFFFF);
      step("wrap2",    1, 0, 0, 0, 1, 0, 16'h0000);
      check_val("wrap2_const", 32'(addr_out), 32'h1);

      // single call / return
      step("jmp20", 1, 1, 0, 0, 0, 0, 16'h0020);
      step("call1", 1, 0, 1, 0, 0, 0, 16'h0100);
      step("rtn1",  1, 0, 0, 1, 0, 0, 16'h0000);
      check_val("rtn1_const", 32'(addr_out), 32'h21);

      // nested calls to overflow, then unwind to underflow
      step("jmp0", 1, 1, 0, 0, 0, 0, 16'h0000);
      for (int i = 1; i <= 5; i++)
         step("nest_call", 1, 0, 1, 0, 0, 0, AW'(i * 16'h0100));
      check_val("nest_ovf_const", 32'(ovf), 32'h1);
      for (int i = 0; i < 5; i++)
         step("nest_rtn", 1, 0, 0, 1, 0, 0, 16'h0000);
      check_val("nest_unf_const", 32'(unf), 32'h1);

      // priority
      step("pri_call", 1, 0, 1, 0, 0, 0, 16'h0300);
      step("pri_all",  1, 1, 1, 1, 0, 0, 16'hABCD);
      step("pri_jskz", 1, 1, 0, 0, 1, 0, 16'h0777);

      // en low freezes everything
      step("hold_call", 1, 0, 1, 0, 0, 0, 16'h0400);
      step("hold_j",    0, 1, 0, 0, 0, 0, 16'h1234);
      step("hold_c",    0, 0, 1, 0, 0, 0, 16'h2345);
      step("hold_r",    0, 0, 0, 1, 0, 0, 16'h0000);
      step("hold_s",    0, 0, 0, 0, 1, 0, 16'h0000);

      // random phase
      for (int n = 0; n < 3000; n++) begin
         logic [AW-1:0] a;
         a = AW'($urandom);
         if ($urandom_range(0, 7) == 0) a = 16'hFFFF - AW'($urandom_range(0, 2));
         step("rand", ($urandom_range(0, 99) < 85), ($urandom_range(0, 3) == 0),
              ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
              ($urandom_range(0, 2) == 0), 1'($urandom), a);
      end

      // reset again mid-cycle after random activity, held across an edge
      #3 reset = 1'b0;
      model_reset();
      #1;
      check_all("async_rst2");
      en = 1; jmp = 1; addr_in = 16'h5555;
      @(posedge pc_clk);
      #1;
      check_all("rst_held");
      @(negedge pc_clk);
      reset = 1'b1;
      #4;
      step("post_rst", 1, 0, 0, 0, 0, 0, 16'h0000);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
